// File: rtl/batcharger_ctrl.sv
// Li-Po charge controller: filters ADC samples and sequences trickle/CC/CV/done/fault for the power stage.
// Optional macro BATCHARGER_CTRL_CYCLECNT_EN builds the completed-charge-cycle counter on chg_cycles.
module batcharger_ctrl #(
    parameter int VTC    = 154,
    parameter int VCV    = 214,
    parameter int VRCH   = 204,
    parameter int TMIN   = 0,
    parameter int TMAX   = 125,
    parameter int FILT   = 4,
    parameter int TC_TMO = 1000000,
    parameter int CV_TMO = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  sel,
    input  logic        smp_vld,
    input  logic [7:0]  vbat,
    input  logic [7:0]  ibat,
    input  logic [7:0]  vtbat,
    output logic        chg_en,
    output logic [1:0]  mode,
    output logic [7:0]  iset,
    output logic        fault,
    output logic        done,
    output logic [15:0] chg_cycles
);
    typedef enum logic [2:0] {S_IDLE, S_TC, S_CC, S_CV, S_DONE, S_FAULT} state_t;

    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

    state_t        state_q, state_d, tgt;
    logic [FW-1:0] filt_q, filt_d;
    logic [31:0]   timer_q, timer_d;
    logic          tmo_flt_q, tmo_flt_d;
    logic          chg_en_q, chg_en_d, fault_q, fault_d, done_q, done_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    iset_q, iset_d, k8;
    logic          temp_bad, qual, tmo;
    int            vb_i, vt_i;

    always_comb begin
        vb_i     = {24'd0, vbat};
        vt_i     = {24'd0, vtbat};
        k8       = {4'd0, sel} + 8'd1;
        temp_bad = (vt_i < TMIN) || (vt_i > TMAX);
        qual     = 1'b0;
        tgt      = state_q;
        tmo      = 1'b0;
        // Temperature outranks the voltage condition in every charging-related state
        case (state_q)
            S_IDLE: begin
                qual = 1'b1;
                tgt  = (vb_i < VTC) ? S_TC : S_CC;
            end
            S_TC: begin
                tmo = (timer_q >= 32'(TC_TMO - 1));
                if (temp_bad)          begin qual = 1'b1; tgt = S_FAULT; end
                else if (vb_i >= VTC)  begin qual = 1'b1; tgt = S_CC;    end
            end
            S_CC: begin
                if (temp_bad)          begin qual = 1'b1; tgt = S_FAULT; end
                else if (vb_i >= VCV)  begin qual = 1'b1; tgt = S_CV;    end
            end
            S_CV: begin
                tmo = (timer_q >= 32'(CV_TMO - 1));
                if (temp_bad)          begin qual = 1'b1; tgt = S_FAULT; end
                else if (ibat < k8)    begin qual = 1'b1; tgt = S_DONE;  end
            end
            S_DONE: begin
                if (temp_bad)          begin qual = 1'b1; tgt = S_FAULT; end
                else if (vb_i <= VRCH) begin qual = 1'b1; tgt = S_CC;    end
            end
            S_FAULT: begin
                qual = !temp_bad && !tmo_flt_q;
                tgt  = S_IDLE;
            end
            default: tgt = S_IDLE;
        endcase

        state_d = state_q;
        filt_d  = filt_q;
        if (!en) begin
            state_d = S_IDLE;
            filt_d  = '0;
        end else if (tmo) begin
            state_d = (state_q == S_TC) ? S_FAULT : S_DONE;
        end else if (smp_vld) begin
            if (!qual)                        filt_d  = '0;
            else if (filt_q == FW'(FILT - 1)) state_d = tgt;
            else                              filt_d  = filt_q + 1'b1;
        end

        if (state_d != state_q) begin
            filt_d  = '0;
            timer_d = '0;
        end else begin
            timer_d = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
        end
        tmo_flt_d = (state_d == S_FAULT) && ((state_q == S_FAULT) ? tmo_flt_q : tmo);

        chg_en_d = 1'b0;
        mode_d   = 2'b00;
        iset_d   = 8'd0;
        fault_d  = (state_d == S_FAULT);
        done_d   = (state_d == S_DONE);
        case (state_d)
            S_TC: begin chg_en_d = 1'b1; mode_d = 2'b01; iset_d = k8;         end
            S_CC: begin chg_en_d = 1'b1; mode_d = 2'b10; iset_d = k8 * 8'd10; end
            S_CV: begin chg_en_d = 1'b1; mode_d = 2'b11; iset_d = k8 * 8'd10; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            filt_q    <= '0;
            timer_q   <= '0;
            tmo_flt_q <= 1'b0;
            chg_en_q  <= 1'b0;
            mode_q    <= 2'b00;
            iset_q    <= 8'd0;
            fault_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            timer_q   <= timer_d;
            tmo_flt_q <= tmo_flt_d;
            chg_en_q  <= chg_en_d;
            mode_q    <= mode_d;
            iset_q    <= iset_d;
            fault_q   <= fault_d;
            done_q    <= done_d;
        end
    end

    assign chg_en = chg_en_q;
    assign mode   = mode_q;
    assign iset   = iset_q;
    assign fault  = fault_q;
    assign done   = done_q;

`ifdef BATCHARGER_CTRL_CYCLECNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cyc_q <= 16'd0;
        else if (state_q == S_CV && state_d == S_DONE && cyc_q != 16'hFFFF)
            cyc_q <= cyc_q + 16'd1;
    end

    assign chg_cycles = cyc_q;
`else
    assign chg_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl with shortened timeouts (TC 200, CV 400 cycles).
module tb_batcharger_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  sel = 4'b1000;
    logic        smp_vld = 1'b0;
    logic [7:0]  vbat = 8'd0;
    logic [7:0]  ibat = 8'd100;
    logic [7:0]  vtbat = 8'd50;
    logic        chg_en, fault, done;
    logic [1:0]  mode;
    logic [7:0]  iset;
    logic [15:0] chg_cycles;
    logic [12:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BATCHARGER_CTRL_CYCLECNT_EN
    localparam logic [15:0] CYC1 = 16'd1;
    localparam logic [15:0] CYC2 = 16'd2;
`else
    localparam logic [15:0] CYC1 = 16'd0;
    localparam logic [15:0] CYC2 = 16'd0;
`endif

    // {chg_en, mode, iset, fault, done}
    localparam logic [12:0] O_IDLE  = {1'b0, 2'b00, 8'd0,  1'b0, 1'b0};
    localparam logic [12:0] O_TC    = {1'b1, 2'b01, 8'd9,  1'b0, 1'b0};
    localparam logic [12:0] O_CC    = {1'b1, 2'b10, 8'd90, 1'b0, 1'b0};
    localparam logic [12:0] O_CV    = {1'b1, 2'b11, 8'd90, 1'b0, 1'b0};
    localparam logic [12:0] O_DONE  = {1'b0, 2'b00, 8'd0,  1'b0, 1'b1};
    localparam logic [12:0] O_FAULT = {1'b0, 2'b00, 8'd0,  1'b1, 1'b0};
    localparam logic [12:0] O_CC_S1 = {1'b1, 2'b10, 8'd20, 1'b0, 1'b0};

    assign obs = {chg_en, mode, iset, fault, done};

    batcharger_ctrl #(.TC_TMO(200), .CV_TMO(400)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .smp_vld(smp_vld),
        .vbat(vbat), .ibat(ibat), .vtbat(vtbat),
        .chg_en(chg_en), .mode(mode), .iset(iset), .fault(fault), .done(done),
        .chg_cycles(chg_cycles)
    );

    always #5 clk = ~clk;

    // One-cycle valid strobe; returns on the falling edge after it was captured.
    task automatic sample(input logic [7:0] vb, input logic [7:0] ib, input logic [7:0] vt);
        @(negedge clk);
        vbat = vb; ibat = ib; vtbat = vt; smp_vld = 1'b1;
        @(negedge clk);
        smp_vld = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs !== O_IDLE) begin n_bad++; $display("FAIL reset_outs: got %h want %h", obs, O_IDLE); end
        n_cmp++;
        if (chg_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_cyc: got %0d want 0", chg_cycles); end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_trickle_to_cc;
        repeat (3) sample(8'd140, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_IDLE) begin n_bad++; $display("FAIL idle_3smp: got %h want %h", obs, O_IDLE); end
        sample(8'd140, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_TC) begin n_bad++; $display("FAIL enter_tc: got %h want %h", obs, O_TC); end
        repeat (3) sample(8'd160, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_TC) begin n_bad++; $display("FAIL tc_3smp: got %h want %h", obs, O_TC); end
        sample(8'd160, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CC) begin n_bad++; $display("FAIL enter_cc: got %h want %h", obs, O_CC); end
    endtask

    task automatic test_filter_clear;
        repeat (3) sample(8'd214, 8'd100, 8'd50);
        sample(8'd200, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CC) begin n_bad++; $display("FAIL filt_break: got %h want %h", obs, O_CC); end
        repeat (3) sample(8'd214, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CC) begin n_bad++; $display("FAIL filt_restart: got %h want %h", obs, O_CC); end
        sample(8'd214, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CV) begin n_bad++; $display("FAIL enter_cv: got %h want %h", obs, O_CV); end
    endtask

    task automatic test_cv_done_recharge;
        repeat (3) sample(8'd214, 8'd8, 8'd50);
        n_cmp++;
        if (obs !== O_CV) begin n_bad++; $display("FAIL cv_3smp: got %h want %h", obs, O_CV); end
        sample(8'd214, 8'd8, 8'd50);
        n_cmp++;
        if (obs !== O_DONE) begin n_bad++; $display("FAIL enter_done: got %h want %h", obs, O_DONE); end
        n_cmp++;
        if (chg_cycles !== CYC1) begin n_bad++; $display("FAIL cyc_after_done: got %0d want %0d", chg_cycles, CYC1); end
        repeat (4) sample(8'd204, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CC) begin n_bad++; $display("FAIL recharge_cc: got %h want %h", obs, O_CC); end
    endtask

    task automatic test_sel_change;
        @(negedge clk);
        sel = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (obs !== O_CC_S1) begin n_bad++; $display("FAIL sel_iset: got %h want %h", obs, O_CC_S1); end
        sel = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (obs !== O_CC) begin n_bad++; $display("FAIL sel_restore: got %h want %h", obs, O_CC); end
    endtask

    task automatic test_temp_fault;
        repeat (4) sample(8'd160, 8'd100, 8'd140);
        n_cmp++;
        if (obs !== O_FAULT) begin n_bad++; $display("FAIL temp_fault: got %h want %h", obs, O_FAULT); end
        repeat (3) sample(8'd160, 8'd100, 8'd100);
        n_cmp++;
        if (obs !== O_FAULT) begin n_bad++; $display("FAIL fault_hold: got %h want %h", obs, O_FAULT); end
        sample(8'd160, 8'd100, 8'd100);
        n_cmp++;
        if (obs !== O_IDLE) begin n_bad++; $display("FAIL fault_exit: got %h want %h", obs, O_IDLE); end
    endtask

    task automatic test_tc_timeout;
        repeat (4) sample(8'd140, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_TC) begin n_bad++; $display("FAIL tc_again: got %h want %h", obs, O_TC); end
        repeat (199) @(negedge clk);
        n_cmp++;
        if (obs !== O_TC) begin n_bad++; $display("FAIL tc_199: got %h want %h", obs, O_TC); end
        @(negedge clk);
        n_cmp++;
        if (obs !== O_FAULT) begin n_bad++; $display("FAIL tc_timeout: got %h want %h", obs, O_FAULT); end
        repeat (4) sample(8'd140, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_FAULT) begin n_bad++; $display("FAIL tmo_sticky: got %h want %h", obs, O_FAULT); end
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== O_IDLE) begin n_bad++; $display("FAIL en_off: got %h want %h", obs, O_IDLE); end
        en = 1'b1;
    endtask

    task automatic test_cv_timeout;
        repeat (4) sample(8'd160, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CC) begin n_bad++; $display("FAIL idle_to_cc: got %h want %h", obs, O_CC); end
        repeat (4) sample(8'd214, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CV) begin n_bad++; $display("FAIL cv_again: got %h want %h", obs, O_CV); end
        repeat (399) @(negedge clk);
        n_cmp++;
        if (obs !== O_CV) begin n_bad++; $display("FAIL cv_399: got %h want %h", obs, O_CV); end
        @(negedge clk);
        n_cmp++;
        if (obs !== O_DONE) begin n_bad++; $display("FAIL cv_timeout: got %h want %h", obs, O_DONE); end
        n_cmp++;
        if (chg_cycles !== CYC2) begin n_bad++; $display("FAIL cyc_after_tmo: got %0d want %0d", chg_cycles, CYC2); end
    endtask

    task automatic test_reset_mid_cv;
        repeat (4) sample(8'd204, 8'd100, 8'd50);
        repeat (4) sample(8'd214, 8'd100, 8'd50);
        n_cmp++;
        if (obs !== O_CV) begin n_bad++; $display("FAIL cv_pre_rst: got %h want %h", obs, O_CV); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin n_bad++; $display("FAIL async_rst: got %h want %h", obs, O_IDLE); end
        n_cmp++;
        if (chg_cycles !== 16'd0) begin n_bad++; $display("FAIL rst_cyc: got %0d want 0", chg_cycles); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== O_IDLE) begin n_bad++; $display("FAIL post_rst_idle: got %h want %h", obs, O_IDLE); end
    endtask

    initial begin
        test_reset;
        test_trickle_to_cc;
        test_filter_clear;
        test_cv_done_recharge;
        test_sel_change;
        test_temp_fault;
        test_tc_timeout;
        test_cv_timeout;
        test_reset_mid_cv;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
